// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and the Kyber twiddle table for the NTT schedule generator.
// ZETA[k] = 17^brv7(k) mod Q in normal (non-Montgomery) form, built at elaboration.
package ntt_pkg;

  localparam int unsigned Q       = 3329;
  localparam int unsigned ZETA_N  = 128;
  localparam int unsigned ZETA_IW = 7;
  localparam int unsigned ZETA_W  = 12;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [ZETA_N-1:0][ZETA_W-1:0] zeta_tab_t;

  // Square-and-multiply over the 7 reversed exponent bits keeps elaboration cheap.
  function automatic zeta_tab_t gen_zeta();
    zeta_tab_t   t;
    int unsigned r;
    int unsigned p;
    int unsigned base;
    t = '0;
    for (int k = 0; k < int'(ZETA_N); k++) begin
      r = 0;
      for (int i = 0; i < 7; i++) begin
        if (((k >> i) & 1) != 0) r = r | (32'd1 << (6 - i));
      end
      p    = 1;
      base = 17;
      for (int i = 0; i < 7; i++) begin
        if (r[i]) p = (p * base) % Q;
        base = (base * base) % Q;
      end
      t[k] = p[ZETA_W-1:0];
    end
    return t;
  endfunction

  localparam zeta_tab_t ZETA = gen_zeta();

endpackage

// File: rtl/ntt_zeta_rom.sv
// Multi-port synchronous twiddle ROM; one read port per butterfly lane.
// Outputs are unreset; the top masks them while no beat is valid.
module ntt_zeta_rom
  import ntt_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned Q_W   = 12
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic [LANES*ZETA_IW-1:0]   idx,
  output logic [LANES*Q_W-1:0]       zeta
);

  always_ff @(posedge clk) begin
    if (en) begin
      for (int l = 0; l < int'(LANES); l++) begin
        zeta[l*Q_W +: Q_W] <= Q_W'(ZETA[idx[l*ZETA_IW +: ZETA_IW]]);
      end
    end
  end

endmodule

// File: rtl/ntt_sched_gen.sv
// On-the-fly Kyber NTT butterfly schedule: per beat, LANES address pairs plus twiddle index/value.
// state | meaning
// IDLE  | waiting for start; mode latched on acceptance
// RUN   | presenting beats of stage s with valid/ready flow control
// GAP   | STAGE_GAP idle cycles between stages; first beat of s+1 loads on the last one
// DONE  | single-cycle done pulse
module ntt_sched_gen
  import ntt_pkg::*;
#(
  parameter int unsigned N         = 256,
  parameter int unsigned LANES     = 2,
  parameter int unsigned STAGES    = 7,
  parameter int unsigned Q_W       = 12,
  parameter int unsigned STAGE_GAP = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          mode,
  output logic                          busy,
  output logic                          done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*$clog2(N)-1:0]    out_addr_a,
  output logic [LANES*$clog2(N)-1:0]    out_addr_b,
  output logic [LANES*STAGES-1:0]       out_zeta_idx,
  output logic [LANES*Q_W-1:0]          out_zeta,
  output logic [2:0]                    out_stage,
  output logic                          out_stage_last
);

  localparam int unsigned AW  = $clog2(N);
  localparam int unsigned KW  = STAGES;
  localparam int unsigned LL  = $clog2(LANES);
  localparam int unsigned BPS = N / (2 * LANES);
  localparam int unsigned CW  = (BPS > 1) ? $clog2(BPS) : 1;
  localparam int unsigned GW  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(BPS - 1);
  localparam logic [2:0]    S_LAST = 3'(STAGES - 1);

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [KW-1:0] k;
  } lane_t;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [2:0]      s_q, s_d;
  logic [CW-1:0]   c_q, c_d;
  logic            pend_q, pend_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            valid_d;
  logic            load;
  logic [2:0]      ld_s;
  logic [CW-1:0]   ld_c;

  logic [LANES*AW-1:0]      ld_a, ld_b;
  logic [LANES*KW-1:0]      ld_k;
  logic [LANES*ZETA_IW-1:0] rom_idx;
  logic [LANES*Q_W-1:0]     rom_zeta;
  lane_t                    ln;

  // len = 2^lg; g and j fall out of a shift and a mask since len is a power of two.
  function automatic lane_t calc_lane(input logic md, input logic [2:0] st,
                                      input logic [CW-1:0] cc, input int unsigned lane);
    int unsigned bv, lg, g, j, a, ng, k;
    lane_t       r;
    bv = (32'(cc) << LL) | lane;
    lg = (md == MODE_INV) ? (AW - STAGES + 32'(st)) : (AW - 1 - 32'(st));
    g  = bv >> lg;
    j  = bv & ((32'd1 << lg) - 1);
    a  = (g << (lg + 1)) | j;
    ng = 32'd1 << (AW - 1 - lg);
    k  = (md == MODE_INV) ? ((ng << 1) - 1 - g) : (ng + g);
    r.a = AW'(a);
    r.b = AW'(a + (32'd1 << lg));
    r.k = KW'(k);
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    s_d     = s_q;
    c_d     = c_q;
    pend_d  = pend_q;
    gap_d   = gap_q;
    valid_d = out_valid;
    load    = 1'b0;
    ld_s    = s_q;
    ld_c    = c_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          s_d     = '0;
          c_d     = '0;
          pend_d  = 1'b0;
        end
      end
      RUN: begin
        if (!out_valid || out_ready) begin
          if (!pend_q) begin
            load = 1'b1;
          end else begin
            valid_d = 1'b0;
            pend_d  = 1'b0;
            if (s_q == S_LAST) begin
              state_d = DONE;
            end else if (STAGE_GAP == 0) begin
              load = 1'b1;
              ld_s = s_q + 3'd1;
              ld_c = '0;
            end else begin
              state_d = GAP;
              gap_d   = GW'(STAGE_GAP - 1);
            end
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = RUN;
          load    = 1'b1;
          ld_s    = s_q + 3'd1;
          ld_c    = '0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      valid_d = 1'b1;
      s_d     = ld_s;
      if (ld_c == C_LAST) begin
        pend_d = 1'b1;
        c_d    = '0;
      end else begin
        c_d = ld_c + 1'b1;
      end
    end
  end

  always_comb begin
    ld_a    = '0;
    ld_b    = '0;
    ld_k    = '0;
    rom_idx = '0;
    ln      = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      ln = calc_lane(mode_q, ld_s, ld_c, l);
      ld_a[l*AW +: AW]              = ln.a;
      ld_b[l*AW +: AW]              = ln.b;
      ld_k[l*KW +: KW]              = ln.k;
      rom_idx[l*ZETA_IW +: ZETA_IW] = ZETA_IW'(ln.k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q         <= MODE_FWD;
      s_q            <= '0;
      c_q            <= '0;
      pend_q         <= 1'b0;
      gap_q          <= '0;
      out_valid      <= 1'b0;
      out_addr_a     <= '0;
      out_addr_b     <= '0;
      out_zeta_idx   <= '0;
      out_stage      <= '0;
      out_stage_last <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      s_q       <= s_d;
      c_q       <= c_d;
      pend_q    <= pend_d;
      gap_q     <= gap_d;
      out_valid <= valid_d;
      if (load) begin
        out_addr_a     <= ld_a;
        out_addr_b     <= ld_b;
        out_zeta_idx   <= ld_k;
        out_stage      <= ld_s;
        out_stage_last <= (ld_c == C_LAST);
      end
    end
  end

  ntt_zeta_rom #(
    .LANES (LANES),
    .Q_W   (Q_W)
  ) u_rom (
    .clk  (clk),
    .en   (load),
    .idx  (rom_idx),
    .zeta (rom_zeta)
  );

  assign out_zeta = {(LANES*Q_W){out_valid}} & rom_zeta;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_ntt_sched_gen.sv
// Randomised-backpressure bench for ntt_sched_gen against a division/modulo reference of the schedule.
module tb_ntt_sched_gen;

  localparam int N      = 256;
  localparam int L      = 2;
  localparam int L4     = 4;
  localparam int STAGES = 7;
  localparam int QW     = 12;
  localparam int GAP    = 4;
  localparam int AW     = 8;
  localparam int KW     = 7;
  localparam int BPS    = N / (2 * L);
  localparam int TOTAL  = BPS * STAGES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic busy, done, out_valid, out_stage_last;
  logic [L*AW-1:0] out_addr_a, out_addr_b;
  logic [L*KW-1:0] out_zeta_idx;
  logic [L*QW-1:0] out_zeta;
  logic [2:0]      out_stage;

  logic start4 = 1'b0, mode4 = 1'b0, ready4 = 1'b1;
  logic busy4, done4, valid4, last4;
  logic [L4*AW-1:0] a4, b4;
  logic [L4*KW-1:0] k4;
  logic [L4*QW-1:0] z4;
  logic [2:0]       stage4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ntt_sched_gen #(.N(N), .LANES(L), .STAGES(STAGES), .Q_W(QW), .STAGE_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr_a(out_addr_a), .out_addr_b(out_addr_b),
    .out_zeta_idx(out_zeta_idx), .out_zeta(out_zeta), .out_stage(out_stage),
    .out_stage_last(out_stage_last)
  );

  ntt_sched_gen #(.N(N), .LANES(L4), .STAGES(STAGES), .Q_W(QW), .STAGE_GAP(GAP)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .busy(busy4), .done(done4),
    .out_valid(valid4), .out_ready(ready4), .out_addr_a(a4), .out_addr_b(b4),
    .out_zeta_idx(k4), .out_zeta(z4), .out_stage(stage4), .out_stage_last(last4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int zeta_ref(input int k);
    int r = 0;
    int p = 1;
    for (int i = 0; i < 7; i++) if (((k >> i) & 1) != 0) r += (1 << (6 - i));
    for (int e = 0; e < r; e++) p = (p * 17) % 3329;
    return p;
  endfunction

  function automatic void model_beat(input logic md, input int lanes, input int idx, input int l,
                                     output int a, output int b, output int k);
    int bps, s, c, bb, len, g, j, ng;
    bps = N / (2 * lanes);
    s   = idx / bps;
    c   = idx % bps;
    bb  = c * lanes + l;
    len = md ? ((N >> STAGES) << s) : ((N / 2) >> s);
    g   = bb / len;
    j   = bb % len;
    a   = 2 * g * len + j;
    b   = a + len;
    ng  = N / (2 * len);
    k   = md ? (2 * ng - 1 - g) : (ng + g);
  endfunction

  task automatic run_sched(input logic md, input int rdy_pct, input int poke_at, input int abort_at);
    int idx, gap_cnt, gap_total, a, b, k;
    bit rdy, stall, fin, poked, closed;
    logic [L*AW-1:0] ea, eb;
    logic [L*KW-1:0] ek;
    logic [L*QW-1:0] ez;
    logic [63:0] s_ab, s_ix, s_z;
    idx = 0; gap_cnt = 0; gap_total = 0;
    stall = 0; fin = 0; poked = 0; closed = 0;
    s_ab = '0; s_ix = '0; s_z = '0;
    @(negedge clk);
    mode = md; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = ~md;
    check("busy_on_start", busy, 1);
    check("valid_before_load", out_valid, 0);
    for (int cyc = 0; cyc < 4000 && !closed; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 0) check("first_beat_latency", out_valid, 1);
      if (fin) begin
        check("done_pulse", {busy, done, out_valid}, 3'b110);
        @(negedge clk);
        check("done_clear", {busy, done}, 2'b00);
        closed = 1;
      end else begin
        check("no_early_done", done, 0);
        if (out_valid) begin
          if (stall) begin
            check("stall_addr", {out_addr_a, out_addr_b}, s_ab);
            check("stall_idx", {out_zeta_idx, out_stage, out_stage_last}, s_ix);
            check("stall_zeta", out_zeta, s_z);
          end else if (idx > 0 && idx % BPS == 0) begin
            check("gap_len", gap_cnt, GAP);
            gap_total += gap_cnt;
          end
          ea = '0; eb = '0; ek = '0; ez = '0;
          for (int l = 0; l < L; l++) begin
            model_beat(md, L, idx, l, a, b, k);
            ea[l*AW +: AW] = AW'(a);
            eb[l*AW +: AW] = AW'(b);
            ek[l*KW +: KW] = KW'(k);
            ez[l*QW +: QW] = QW'(zeta_ref(k));
          end
          check("beat_addr", {out_addr_a, out_addr_b}, {ea, eb});
          check("beat_idx", {out_zeta_idx, out_stage, out_stage_last},
                {ek, 3'(idx / BPS), (idx % BPS) == BPS - 1});
          check("beat_zeta", out_zeta, ez);
          if (!md && idx == 0) check("fwd_first_zeta", out_zeta, {12'd1729, 12'd1729});
          s_ab = {out_addr_a, out_addr_b};
          s_ix = {out_zeta_idx, out_stage, out_stage_last};
          s_z  = out_zeta;
          rdy = ($urandom_range(99) < rdy_pct);
          out_ready = rdy;
          stall = !rdy;
          if (rdy) begin
            if (idx % BPS == BPS - 1) gap_cnt = 0;
            idx++;
            if (idx == TOTAL) fin = 1;
          end
        end else begin
          gap_cnt++;
          stall = 0;
          out_ready = ($urandom_range(99) < rdy_pct);
        end
        if (poke_at == idx && !poked) begin
          start = 1'b1;
          poked = 1;
        end
        if (abort_at == idx) begin
          #1 rst_n = 1'b0;
          #1;
          check("abort_ctrl", {busy, done, out_valid, out_stage, out_stage_last}, 0);
          check("abort_addr", {out_addr_a, out_addr_b, out_zeta_idx}, 0);
          check("abort_zeta", out_zeta, 0);
          repeat (3) begin
            @(negedge clk);
            check("abort_no_done", {done, busy}, 0);
          end
          rst_n = 1'b1;
          return;
        end
      end
    end
    check("beats_total", idx, TOTAL);
    check("gap_total", gap_total, GAP * (STAGES - 1));
    check("sched_closed", closed, 1);
  endtask

  task automatic run_lanes4();
    int n4, a, b, k;
    bit seen1;
    logic [L4*AW-1:0] ea, eb;
    logic [L4*QW-1:0] ez;
    n4 = 0; seen1 = 0;
    @(negedge clk);
    start4 = 1'b1; mode4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen1; cyc++) begin
      @(negedge clk);
      if (valid4) begin
        if (stage4 != 3'd0) begin
          seen1 = 1;
        end else begin
          ea = '0; eb = '0; ez = '0;
          for (int l = 0; l < L4; l++) begin
            model_beat(1'b0, L4, n4, l, a, b, k);
            ea[l*AW +: AW] = AW'(a);
            eb[l*AW +: AW] = AW'(b);
            ez[l*QW +: QW] = QW'(zeta_ref(k));
          end
          check("l4_addr", {a4, b4}, {ea, eb});
          check("l4_zeta", z4, ez);
          if (n4 == 0) check("l4_first", {a4, b4}, 64'h03020100_83828180);
          n4++;
          if (last4) check("l4_last_pos", n4, BPS / 2);
        end
      end
    end
    check("l4_beats_per_stage", n4, N / (2 * L4));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    #12;
    check("reset_ctrl", {busy, done, out_valid, out_stage, out_stage_last}, 0);
    check("reset_data", {out_addr_a, out_addr_b, out_zeta_idx, out_zeta}, 0);
    check("reset_l4", {busy4, done4, valid4}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sched(1'b0, 100, 10, -1);
    run_sched(1'b1, 100, -1, -1);
    run_sched(1'b0, 50, -1, -1);
    run_sched(1'b0, 100, -1, 100);
    run_sched(1'b0, 100, -1, -1);
    run_sched(1'b1, 50, -1, -1);
    run_lanes4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
